// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if
//   Request/response bundle for the pipelined barrel shifter.
//   master : issues requests, consumes results (ALU side)
//   slave  : the shift unit
//   Signals:
//     in_valid/in_ready    request handshake
//     in_data, in_shamt    operand and shift amount (0..WIDTH-1)
//     in_mode              00 SLL, 01 SRL, 10 SRA, 11 ROR
//     in_tag               sideband returned with the result
//     out_valid/out_ready  result handshake
//     out_data, out_tag    result and its tag
//     busy                 any operation is held inside the unit
interface pipelined_barrel_shifter_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHAMT_W-1:0] in_shamt;
   logic [1:0]         in_mode;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [TAG_W-1:0]   out_tag;
   logic               busy;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, busy
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, busy
   );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Pipelined barrel shifter (SLL/SRL/SRA/ROR) built from log2(WIDTH) binary
//   shift stages, largest shift first, with a register after every REG_EVERY
//   stages. Valid/ready handshake on both sides with full backpressure;
//   bubbles collapse while the output is stalled.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    request/response bundle (slave modport)
module pipelined_barrel_shifter #(
   parameter int WIDTH     = 32,
   parameter int REG_EVERY = 2,
   parameter int TAG_W     = 4
) (
   input logic                        clock,
   input logic                        reset,
   pipelined_barrel_shifter_if.slave  bus
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int LAT     = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

   // pipeline registers, one entry per register slot
   logic               valid_reg [LAT];
   logic [WIDTH-1:0]   data_reg  [LAT];
   logic [SHAMT_W-1:0] shamt_reg [LAT];
   logic [1:0]         mode_reg  [LAT];
   logic               sign_reg  [LAT];
   logic [TAG_W-1:0]   tag_reg   [LAT];

   // inputs of the stage group feeding each register
   logic               grp_valid [LAT];
   logic [WIDTH-1:0]   grp_data  [LAT];
   logic [SHAMT_W-1:0] grp_shamt [LAT];
   logic [1:0]         grp_mode  [LAT];
   logic               grp_sign  [LAT];
   logic [TAG_W-1:0]   grp_tag   [LAT];

   // data as it flows through the stages of one group
   logic [WIDTH-1:0]   chain [LAT][REG_EVERY+1];

   // register i loads this cycle
   logic               adv [LAT];

   assign adv[LAT-1] = ~valid_reg[LAT-1] | bus.out_ready;

   genvar gi, gj;
   generate
      for (gi = 0; gi < LAT - 1; gi++) begin : g_adv
         assign adv[gi] = ~valid_reg[gi] | adv[gi+1];
      end

      for (gi = 0; gi < LAT; gi++) begin : g_grp
         if (gi == 0) begin : g_src_in
            assign grp_valid[gi] = bus.in_valid;
            assign grp_data[gi]  = bus.in_data;
            assign grp_shamt[gi] = bus.in_shamt;
            assign grp_mode[gi]  = bus.in_mode;
            // SRA fill is the operand's sign at entry to the pipe
            assign grp_sign[gi]  = bus.in_data[WIDTH-1];
            assign grp_tag[gi]   = bus.in_tag;
         end else begin : g_src_reg
            assign grp_valid[gi] = valid_reg[gi-1];
            assign grp_data[gi]  = data_reg[gi-1];
            assign grp_shamt[gi] = shamt_reg[gi-1];
            assign grp_mode[gi]  = mode_reg[gi-1];
            assign grp_sign[gi]  = sign_reg[gi-1];
            assign grp_tag[gi]   = tag_reg[gi-1];
         end

         assign chain[gi][0] = grp_data[gi];

         for (gj = 0; gj < REG_EVERY; gj++) begin : g_stage
            localparam int K = gi * REG_EVERY + gj;
            if (K < SHAMT_W) begin : g_shift
               localparam int SH = 1 << (SHAMT_W - 1 - K);
               logic [WIDTH-1:0] d;
               logic [WIDTH-1:0] r;
               assign d = chain[gi][gj];
               always_comb begin
                  r = d;
                  if (grp_shamt[gi][SHAMT_W-1-K]) begin
                     case (grp_mode[gi])
                        2'b00:   r = d << SH;
                        2'b01:   r = d >> SH;
                        2'b10:   r = grp_sign[gi] ? ~(~d >> SH) : (d >> SH);
                        default: r = (d >> SH) | (d << (WIDTH - SH));
                     endcase
                  end
               end
               assign chain[gi][gj+1] = r;
            end else begin : g_pass
               // last group may hold fewer than REG_EVERY real stages
               assign chain[gi][gj+1] = chain[gi][gj];
            end
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               valid_reg[gi] <= 1'b0;
               data_reg[gi]  <= '0;
               shamt_reg[gi] <= '0;
               mode_reg[gi]  <= '0;
               sign_reg[gi]  <= 1'b0;
               tag_reg[gi]   <= '0;
            end else if (adv[gi]) begin
               valid_reg[gi] <= grp_valid[gi];
               data_reg[gi]  <= chain[gi][REG_EVERY];
               shamt_reg[gi] <= grp_shamt[gi];
               mode_reg[gi]  <= grp_mode[gi];
               sign_reg[gi]  <= grp_sign[gi];
               tag_reg[gi]   <= grp_tag[gi];
            end
         end
      end
   endgenerate

   logic busy_next;
   always_comb begin
      busy_next = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         busy_next = busy_next | valid_reg[i];
      end
   end

   // gated by reset so no request is accepted while reset is held
   assign bus.in_ready  = reset & adv[0];
   assign bus.out_valid = valid_reg[LAT-1];
   assign bus.out_data  = data_reg[LAT-1];
   assign bus.out_tag   = tag_reg[LAT-1];
   assign bus.busy      = busy_next;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
   localparam int WIDTH     = 32;
   localparam int REG_EVERY = 2;
   localparam int TAG_W     = 4;
   localparam int LAT       = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

   pipelined_barrel_shifter #(
      .WIDTH(WIDTH), .REG_EVERY(REG_EVERY), .TAG_W(TAG_W)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [TAG_W-1:0] tag;
   } res_t;
   res_t sb[$];

   // reference: shift semantics straight from the mode definitions
   function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                  input int sh, input logic [1:0] m);
      logic [2*WIDTH-1:0] w;
      logic [WIDTH-1:0] r;
      case (m)
         2'b00: r = d << sh;
         2'b01: r = d >> sh;
         2'b10: begin w = {{WIDTH{d[WIDTH-1]}}, d}; w = w >> sh; r = w[WIDTH-1:0]; end
         default: begin w = {d, d}; w = w >> sh; r = w[WIDTH-1:0]; end
      endcase
      return r;
   endfunction

   task automatic drive_idle();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_shamt = '0;
      bus.in_mode  = '0;
      bus.in_tag   = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic run_single(input string name, input logic [WIDTH-1:0] d, input int sh,
                             input logic [1:0] m, input logic [WIDTH-1:0] exp);
      int lat;
      bit seen;
      logic [4:0] sh5;
      sh5 = sh[4:0];
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_shamt = sh5;
      bus.in_mode = m; bus.in_tag = 4'hA; bus.out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready got=%b want=1", name, bus.in_ready); end
      @(posedge clk); #1;
      drive_idle();
      lat = 0; seen = 0;
      for (int c = 1; c <= 8 && !seen; c++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            seen = 1; lat = c;
            $display("txn %s data=%08h shamt=%0d mode=%0d -> %08h tag=%0h", name, d, sh, m, bus.out_data, bus.out_tag);
            n_checks++;
            if (bus.out_data !== exp) begin n_fail++; $display("FAIL %s_data got=%08h want=%08h", name, bus.out_data, exp); end
            n_checks++;
            if (bus.out_tag !== 4'hA) begin n_fail++; $display("FAIL %s_tag got=%0h want=a", name, bus.out_tag); end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (!seen || lat != LAT) begin n_fail++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
   endtask

   task automatic test_back_to_back();
      int got, first;
      res_t e;
      logic [1:0] m;
      int sh;
      got = 0; first = -1;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (c < 8) begin
            m = 2'($urandom_range(0, 3)); sh = $urandom_range(0, 31);
            bus.in_valid = 1'b1; bus.in_data = $urandom; bus.in_shamt = sh[4:0];
            bus.in_mode = m; bus.in_tag = 4'(c);
         end else begin
            drive_idle();
         end
         @(negedge clk);
         if (c < 8) begin
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", c, bus.in_ready); end
            sb.push_back('{data: ref_shift(bus.in_data, sh, m), tag: 4'(c)});
         end
         if (bus.out_valid === 1'b1) begin
            if (first < 0) first = c;
            n_checks++;
            if (c != first + got) begin n_fail++; $display("FAIL b2b_consecutive cyc=%0d got_gap want=%0d", c, first + got); end
            if (sb.size() == 0) begin
               n_checks++; n_fail++; $display("FAIL b2b_spurious data=%08h tag=%0h want none", bus.out_data, bus.out_tag);
            end else begin
               e = sb.pop_front();
               $display("txn b2b tag=%0h data=%08h", bus.out_tag, bus.out_data);
               n_checks++;
               if (bus.out_data !== e.data || bus.out_tag !== e.tag) begin
                  n_fail++; $display("FAIL b2b_result got=%08h/%0h want=%08h/%0h", bus.out_data, bus.out_tag, e.data, e.tag);
               end
            end
            got++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (got != 8) begin n_fail++; $display("FAIL b2b_count got=%0d want=8", got); end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] od [4];
      logic [4:0] os [4];
      logic [1:0] om [4];
      int issued, got;
      bit held;
      logic [WIDTH-1:0] hd;
      logic [TAG_W-1:0] ht;
      res_t e;
      for (int i = 0; i < 4; i++) begin
         od[i] = $urandom; os[i] = 5'($urandom_range(0, 31)); om[i] = 2'($urandom_range(0, 3));
      end
      issued = 0; got = 0; held = 0; hd = '0; ht = '0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (issued < 4) begin
            bus.in_valid = 1'b1; bus.in_data = od[issued]; bus.in_shamt = os[issued];
            bus.in_mode = om[issued]; bus.in_tag = 4'(8 + issued);
         end else drive_idle();
         @(negedge clk);
         if (c >= 3) begin
            n_checks++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, bus.in_ready); end
         end
         if (bus.out_valid === 1'b1) begin
            if (held) begin
               n_checks++;
               if (bus.out_data !== hd || bus.out_tag !== ht) begin
                  n_fail++; $display("FAIL bp_stable got=%08h/%0h want=%08h/%0h", bus.out_data, bus.out_tag, hd, ht);
               end
            end else begin
               held = 1; hd = bus.out_data; ht = bus.out_tag;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{data: ref_shift(od[issued], int'(os[issued]), om[issued]), tag: 4'(8 + issued)});
            issued++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (issued != 3) begin n_fail++; $display("FAIL bp_accepted got=%0d want=3", issued); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (issued < 4) begin
            bus.in_valid = 1'b1; bus.in_data = od[issued]; bus.in_shamt = os[issued];
            bus.in_mode = om[issued]; bus.in_tag = 4'(8 + issued);
         end else drive_idle();
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++; n_fail++; $display("FAIL bp_spurious data=%08h tag=%0h want none", bus.out_data, bus.out_tag);
            end else begin
               e = sb.pop_front();
               $display("txn bp tag=%0h data=%08h", bus.out_tag, bus.out_data);
               n_checks++;
               if (bus.out_data !== e.data || bus.out_tag !== e.tag) begin
                  n_fail++; $display("FAIL bp_result got=%08h/%0h want=%08h/%0h", bus.out_data, bus.out_tag, e.data, e.tag);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{data: ref_shift(od[issued], int'(os[issued]), om[issued]), tag: 4'(8 + issued)});
            issued++;
         end
         @(posedge clk); #1;
      end
      drive_idle();
      n_checks++;
      if (got != 4 || sb.size() != 0) begin n_fail++; $display("FAIL bp_drain got=%0d left=%0d want=4/0", got, sb.size()); end
   endtask

   task automatic test_reset_inflight();
      bit any_out;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1; bus.in_data = $urandom; bus.in_shamt = 5'd3;
         bus.in_mode = 2'b11; bus.in_tag = 4'(i + 1);
         @(posedge clk); #1;
      end
      drive_idle();
      n_checks++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before got=%b want=1", bus.busy); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_out_valid got=%b want=0", bus.out_valid); end
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b want=0", bus.busy); end
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready got=%b want=1", bus.in_ready); end
      any_out = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.out_valid !== 1'b0) any_out = 1;
         @(negedge clk);
      end
      n_checks++;
      if (any_out) begin n_fail++; $display("FAIL rst_stale_output got=1 want=0"); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int issued, got, cyc, sh;
      bit pending, stall;
      logic [WIDTH-1:0] pd, hd;
      logic [1:0] pm;
      logic [TAG_W-1:0] pt, ht;
      res_t e;
      issued = 0; got = 0; pending = 0; stall = 0;
      pd = '0; pm = '0; pt = '0; sh = 0; hd = '0; ht = '0;
      for (cyc = 0; cyc < 40000 && got < 10000; cyc++) begin
         if (!pending && issued < 10000 && ($urandom_range(0, 3) != 0)) begin
            pending = 1;
            pd = $urandom; sh = $urandom_range(0, 31); pm = 2'($urandom_range(0, 3)); pt = 4'($urandom);
         end
         bus.in_valid = pending; bus.in_data = pd; bus.in_shamt = sh[4:0];
         bus.in_mode = pm; bus.in_tag = pt;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (stall) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_tag !== ht) begin
               n_fail++; $display("FAIL rnd_stall_stable got=%b/%08h/%0h want=1/%08h/%0h", bus.out_valid, bus.out_data, bus.out_tag, hd, ht);
            end
         end
         stall = (bus.out_valid === 1'b1) && !bus.out_ready;
         hd = bus.out_data; ht = bus.out_tag;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_checks++; n_fail++; $display("FAIL rnd_spurious data=%08h tag=%0h want none", bus.out_data, bus.out_tag);
            end else begin
               e = sb.pop_front();
               $display("txn rnd #%0d tag=%0h data=%08h", got, bus.out_tag, bus.out_data);
               n_checks++;
               if (bus.out_data !== e.data || bus.out_tag !== e.tag) begin
                  n_fail++; $display("FAIL rnd_result #%0d got=%08h/%0h want=%08h/%0h", got, bus.out_data, bus.out_tag, e.data, e.tag);
               end
            end
            got++;
         end
         if (pending && bus.in_ready === 1'b1) begin
            sb.push_back('{data: ref_shift(pd, sh, pm), tag: pt});
            issued++;
            pending = 0;
         end
         n_checks++;
         if (sb.size() > LAT) begin n_fail++; $display("FAIL rnd_occupancy got=%0d want<=%0d", sb.size(), LAT); end
         @(posedge clk); #1;
      end
      drive_idle();
      n_checks++;
      if (got != 10000 || sb.size() != 0) begin n_fail++; $display("FAIL rnd_complete got=%0d left=%0d want=10000/0", got, sb.size()); end
   endtask

   initial begin
      drive_idle();
      bus.out_ready = 1'b0;
      test_reset();
      run_single("sra_16",   32'h80000000, 16, 2'b10, 32'hFFFF8000);
      run_single("sra_31",   32'h7FFFFFFF, 31, 2'b10, 32'h00000000);
      run_single("sra_31n",  32'h80000000, 31, 2'b10, 32'hFFFFFFFF);
      run_single("srl_16",   32'h80000000, 16, 2'b01, 32'h00008000);
      run_single("srl_31",   32'hFFFFFFFF, 31, 2'b01, 32'h00000001);
      run_single("sll_31",   32'h00000001, 31, 2'b00, 32'h80000000);
      run_single("sll_31f",  32'hFFFFFFFF, 31, 2'b00, 32'h80000000);
      run_single("ror_1",    32'h00000001, 1,  2'b11, 32'h80000000);
      run_single("ror_31",   32'h80000001, 31, 2'b11, 32'h00000003);
      run_single("sll_0",    32'hA5C30F81, 0,  2'b00, 32'hA5C30F81);
      run_single("srl_0",    32'hA5C30F81, 0,  2'b01, 32'hA5C30F81);
      run_single("sra_0",    32'hA5C30F81, 0,  2'b10, 32'hA5C30F81);
      run_single("ror_0",    32'hA5C30F81, 0,  2'b11, 32'hA5C30F81);
      test_back_to_back();
      test_backpressure();
      test_reset_inflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
